// File: rtl/alu_seq_pkg.sv
// Shared definitions for the multi-word ALU sequencer.
//   state_t : sequencer FSM encoding (IDLE / RUN / DONE)
//   OP_ADD / OP_SUB : encoding of the op_sub command bit
package alu_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/alu_carry_reg.sv
// Single-bit carry storage for the chained ALU slices.
// Updates on the falling edge of clk; asynchronous active-high reset.
//   clk      in  processor clock (state changes on negedge)
//   rst      in  asynchronous active-high reset, clears q
//   seed_en  in  load seed_val (start of a new operation); wins over load_en
//   seed_val in  seed value (1 for SUB, 0 for ADD)
//   load_en  in  capture d (carry-out of the current slice)
//   d        in  carry-out of the current slice
//   q        out stored carry
module alu_carry_reg (
  input  logic clk,
  input  logic rst,
  input  logic seed_en,
  input  logic seed_val,
  input  logic load_en,
  input  logic d,
  output logic q
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q;
    if (seed_en) begin
      q_d = seed_val;
    end else if (load_en) begin
      q_d = d;
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/alu_multiword_sequencer.sv
// Sequences an extended-precision ADD/SUB through a single-word ALU,
// one word slice per cycle, chaining carry-out of slice k into slice k+1.
// All state updates on the falling edge of clk; asynchronous active-high rst.
//   start/op_sub/nwords/abort : command interface from the control unit
//   alu_cout                  : carry-out of the slice currently on the ALU
//   alu_en/alu_sub/alu_cin/word_idx : drive the ALU datapath
//   busy/done/err/carry_out   : status back to the control unit
module alu_multiword_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WORDS_MAX = 4,
  parameter int CNT_W     = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_sub,
  input  logic [CNT_W-1:0] nwords,
  input  logic             abort,
  input  logic             alu_cout,
  output logic             alu_en,
  output logic             alu_sub,
  output logic             alu_cin,
  output logic [CNT_W-1:0] word_idx,
  output logic             busy,
  output logic             done,
  output logic             carry_out,
  output logic             err
);

  state_t           state_q, state_d;
  logic             sub_q, sub_d;
  logic [CNT_W-1:0] nwords_q, nwords_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic             err_q, err_d;
  logic             cout_q, cout_d;

  logic             seed_en;
  logic             seed_val;
  logic             load_en;
  logic             carry_q;

  alu_carry_reg u_carry (
    .clk      (clk),
    .rst      (rst),
    .seed_en  (seed_en),
    .seed_val (seed_val),
    .load_en  (load_en),
    .d        (alu_cout),
    .q        (carry_q)
  );

  always_comb begin
    state_d  = state_q;
    sub_d    = sub_q;
    nwords_d = nwords_q;
    idx_d    = idx_q;
    err_d    = err_q;
    cout_d   = cout_q;
    seed_en  = 1'b0;
    seed_val = (op_sub == OP_SUB);  // SUB is A + ~B + 1: first slice gets cin=1
    load_en  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // abort beats a simultaneous start
        if (start && !abort) begin
          sub_d    = op_sub;
          nwords_d = nwords;
          idx_d    = '0;
          seed_en  = 1'b1;
          if (nwords == '0 || nwords > CNT_W'(WORDS_MAX)) begin
            // illegal length: report immediately, no ALU cycles
            err_d   = 1'b1;
            cout_d  = 1'b0;
            state_d = ST_DONE;
          end else begin
            err_d   = 1'b0;
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          load_en = 1'b1;
          if (idx_q == nwords_q - CNT_W'(1)) begin
            cout_d  = alu_cout;
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + CNT_W'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      sub_q    <= 1'b0;
      nwords_q <= '0;
      idx_q    <= '0;
      err_q    <= 1'b0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sub_q    <= sub_d;
      nwords_q <= nwords_d;
      idx_q    <= idx_d;
      err_q    <= err_d;
      cout_q   <= cout_d;
    end
  end

  // Outputs come from registered state only; start never reaches them.
  // abort in DONE suppresses the completion pulse of that cycle.
  assign alu_en    = (state_q == ST_RUN);
  assign alu_sub   = sub_q;
  assign alu_cin   = carry_q;
  assign word_idx  = idx_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE) && !abort;
  assign err       = done && err_q;
  assign carry_out = cout_q;

endmodule

// File: tb/tb_alu_multiword_sequencer.sv
module tb_alu_multiword_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic       op_sub;
  logic [2:0] nwords;
  logic       abort;
  logic       alu_cout;
  logic       alu_en;
  logic       alu_sub;
  logic       alu_cin;
  logic [2:0] word_idx;
  logic       busy;
  logic       done;
  logic       carry_out;
  logic       err;

  alu_multiword_sequencer #(.WORDS_MAX(4), .CNT_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op_sub    (op_sub),
    .nwords    (nwords),
    .abort     (abort),
    .alu_cout  (alu_cout),
    .alu_en    (alu_en),
    .alu_sub   (alu_sub),
    .alu_cin   (alu_cin),
    .word_idx  (word_idx),
    .busy      (busy),
    .done      (done),
    .carry_out (carry_out),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-word ALU operating on 4x32-bit operands
  logic [127:0] a_bus, b_bus;
  logic [32:0]  sum;
  logic [31:0]  bw;
  always_comb begin
    bw  = b_bus[word_idx[1:0]*32 +: 32];
    if (alu_sub) bw = ~bw;
    sum = {1'b0, a_bus[word_idx[1:0]*32 +: 32]} + {1'b0, bw} + {32'd0, alu_cin};
  end
  assign alu_cout = sum[32];

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic         sub;
    logic [2:0]   n;
    logic [127:0] a;
    logic [127:0] b;
    logic         hold;     // keep start high until done is seen
    logic [127:0] res;
    logic         cout;
    logic         er;
    int           edges;    // edges from start edge to done visible
    int           en_cnt;
    logic         cin0;
  } vec_t;

  vec_t vecs[8];

  // Runs one command; start is driven on a posedge, DUT acts on the next negedge.
  task automatic run_vec(input vec_t v, input string tag);
    logic [127:0] result;
    int edges, done_edge, done_cnt, en_cnt;
    logic idx_ok, cin0, err_s, cout_s;
    result = '0; done_edge = 0; done_cnt = 0; en_cnt = 0;
    idx_ok = 1'b1; cin0 = 1'b0; err_s = 1'b0; cout_s = 1'b0;
    a_bus = v.a; b_bus = v.b;
    @(posedge clk);
    op_sub = v.sub; nwords = v.n; start = 1'b1;
    for (edges = 1; edges <= 10; edges++) begin
      @(posedge clk);
      if (!v.hold) begin
        start = 1'b0; op_sub = ~v.sub; nwords = 3'd7;
      end
      if (alu_en) begin
        result[en_cnt*32 +: 32] = sum[31:0];
        if (word_idx != 3'(en_cnt)) idx_ok = 1'b0;
        if (en_cnt == 0) cin0 = alu_cin;
        en_cnt++;
      end
      if (done) begin
        done_cnt++;
        done_edge = edges;
        err_s = err;
        cout_s = carry_out;
        start = 1'b0;
      end
    end
    chk({tag, " done_edge"}, 128'(done_edge), 128'(v.edges));
    chk({tag, " done_count"}, 128'(done_cnt), 128'd1);
    chk({tag, " err"}, 128'(err_s), 128'(v.er));
    chk({tag, " carry_out"}, 128'(cout_s), 128'(v.cout));
    chk({tag, " alu_en_cycles"}, 128'(en_cnt), 128'(v.en_cnt));
    chk({tag, " cin0"}, 128'(cin0), 128'(v.cin0));
    chk({tag, " word_idx_seq"}, 128'(idx_ok), 128'd1);
    chk({tag, " busy_end"}, 128'(busy), 128'd0);
    if (v.en_cnt > 0) chk({tag, " result"}, result, v.res);
    $display("vec %s: sub=%0d n=%0d result=0x%0h carry_out=%0d err=%0d done_edge=%0d",
             tag, v.sub, v.n, result, cout_s, err_s, done_edge);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " alu_en"}, 128'(alu_en), 128'd0);
    chk({tag, " alu_sub"}, 128'(alu_sub), 128'd0);
    chk({tag, " alu_cin"}, 128'(alu_cin), 128'd0);
    chk({tag, " word_idx"}, 128'(word_idx), 128'd0);
    chk({tag, " busy"}, 128'(busy), 128'd0);
    chk({tag, " done"}, 128'(done), 128'd0);
    chk({tag, " carry_out"}, 128'(carry_out), 128'd0);
    chk({tag, " err"}, 128'(err), 128'd0);
  endtask

  initial begin
    int seen_done;
    //            sub   n     a                                          b                                          hold  res                                         cout  er    edges en cin0
    vecs[0] = '{1'b0, 3'd2, 128'h0_00000001_FFFFFFFF,                  128'h1,                                    1'b0, 128'h0_00000002_00000000,                  1'b0, 1'b0, 3, 2, 1'b0};
    vecs[1] = '{1'b0, 3'd1, 128'hFFFFFFFF,                             128'h1,                                    1'b0, 128'h0,                                    1'b1, 1'b0, 2, 1, 1'b0};
    vecs[2] = '{1'b0, 3'd0, 128'h0,                                    128'h0,                                    1'b0, 128'h0,                                    1'b0, 1'b1, 1, 0, 1'b0};
    vecs[3] = '{1'b1, 3'd4, 128'h0,                                    128'h1,                                    1'b0, {4{32'hFFFFFFFF}},                         1'b0, 1'b0, 5, 4, 1'b1};
    vecs[4] = '{1'b1, 3'd1, 128'h5,                                    128'h3,                                    1'b0, 128'h2,                                    1'b1, 1'b0, 2, 1, 1'b1};
    vecs[5] = '{1'b1, 3'd5, 128'h0,                                    128'h0,                                    1'b0, 128'h0,                                    1'b0, 1'b1, 1, 0, 1'b0};
    vecs[6] = '{1'b0, 3'd3, 128'h0_FFFFFFFF_FFFFFFFF,                  128'h1,                                    1'b1, 128'h1_00000000_00000000,                  1'b0, 1'b0, 4, 3, 1'b0};
    vecs[7] = '{1'b0, 3'd4, {4{32'hFFFFFFFF}},                         128'h1,                                    1'b0, 128'h0,                                    1'b1, 1'b0, 5, 4, 1'b0};

    rst = 1'b1; start = 1'b0; op_sub = 1'b0; nwords = 3'd0; abort = 1'b0;
    a_bus = '0; b_bus = '0;
    #3;
    chk_reset_outputs("reset");
    @(posedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // abort during word_idx=1 of a 4-word op; carry_out stays 1 from vecs[7]
    a_bus = '0; b_bus = '0;
    @(posedge clk);
    op_sub = 1'b0; nwords = 3'd4; start = 1'b1;
    @(posedge clk); start = 1'b0;
    chk("abort idx0", 128'(word_idx), 128'd0);
    @(posedge clk);
    chk("abort idx1", 128'(word_idx), 128'd1);
    abort = 1'b1;
    @(posedge clk);
    abort = 1'b0;
    chk("abort busy", 128'(busy), 128'd0);
    chk("abort alu_en", 128'(alu_en), 128'd0);
    seen_done = 0;
    for (int e = 0; e < 6; e++) begin
      @(posedge clk);
      if (done) seen_done++;
    end
    chk("abort no_done", 128'(seen_done), 128'd0);
    chk("abort carry_out", 128'(carry_out), 128'd1);
    $display("seq abort: busy=%0d carry_out=%0d done_seen=%0d", busy, carry_out, seen_done);

    // abort together with start in IDLE: stays idle
    start = 1'b1; abort = 1'b1; nwords = 3'd2;
    @(posedge clk);
    start = 1'b0; abort = 1'b0;
    chk("abort_start busy", 128'(busy), 128'd0);
    $display("seq abort+start: busy=%0d", busy);

    // async reset mid-RUN, then a fresh op
    a_bus = '0; b_bus = '0;
    op_sub = 1'b1; nwords = 3'd4; start = 1'b1;
    @(posedge clk); start = 1'b0;
    @(posedge clk);
    chk("rst pre busy", 128'(busy), 128'd1);
    #2 rst = 1'b1;
    #1;
    chk_reset_outputs("rst_mid");
    $display("seq rst mid-run: busy=%0d alu_en=%0d word_idx=%0d", busy, alu_en, word_idx);
    @(posedge clk);
    rst = 1'b0;
    run_vec(vecs[0], "post_rst");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
